lifo_stack: RTL and testbench
=============================

// Module: lifo_stack
//
// PURPOSE
//  Parametrised LIFO for return addresses and operand saves in the DE0_CV CPU datapath.
//  Generalises the fixed 11x16 stack in width and depth, and adds:
//   - full/empty flags and an occupancy count;
//   - overflow/underflow strobes;
//   - a defined simultaneous push+pop (replace top);
//   - an optional circular-overwrite mode for call-depth overrun.
//
// PARAMETERS
//  WIDTH  11  data bits per entry (>=1)
//  DEPTH  16  number of entries (>=2; need not be a power of 2)
//  AW     $clog2(DEPTH)    localparam, top-pointer width
//  CW     $clog2(DEPTH+1)  localparam, count width
//
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  reset      in   1      synchronous, active-high; priority over push/pop
//  push       in   1      write din as new top this cycle
//  pop        in   1      discard current top this cycle
//  din        in   WIDTH  push data
//  dout       out  WIDTH  current top (combinational from state); '0 when empty
//  empty      out  1      count==0
//  full       out  1      count==DEPTH
//  count      out  CW     number of valid entries
//  overflow   out  1      registered 1-cycle strobe: push issued while full
//  underflow  out  1      registered 1-cycle strobe: pop issued while empty
//
// BEHAVIOUR
//  Reset values (clock edge with reset=1):
//   - count=0, top=DEPTH-1, empty=1, full=0, overflow=0, underflow=0, dout='0.
//   - Storage array is not reset.
//  Latency: the result of a push or pop appears on dout/count/flags in the cycle
//  after the edge; dout has no read latency.
//  Top pointer: increments/decrements modulo DEPTH with an explicit wrap compare
//  (DEPTH-1 -> 0 and 0 -> DEPTH-1); no reliance on power-of-2 rollover.
//  Operation per edge (reset=0):
//   - idle (push=0, pop=0): no change; strobes 0.
//   - push only, not full: mem[top+1]<=din; top++; count++.
//   - push only, full: see CONFIGURATION; overflow=1.
//   - pop only, not empty: top--; count--.
//   - pop only, empty: no change; underflow=1.
//   - push+pop, not empty (full included): mem[top]<=din; top and count unchanged;
//     no strobe.
//   - push+pop, empty: executes as push only (count becomes 1); underflow=1.
//  Strobes are recomputed every cycle and are never sticky.
//  Reset mid-sequence discards all entries; the next push lands at index 0.
//
// CONFIGURATION
//  LIFO_STACK_WRAP_EN
//   - Defined: a push while full overwrites the oldest entry, writing
//     mem[top+1 mod DEPTH]<=din. top advances, count stays DEPTH, and overflow=1.
//     The next DEPTH pops return the newest DEPTH values.
//   - Undefined: a push while full is dropped. mem, top and count are unchanged,
//     and overflow=1.
//
// STRUCTURE
//  Package stack_pkg:
//   - typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPL} stk_op_t;
//   - function ptr_inc/ptr_dec(ptr, depth) for modular pointer arithmetic.
//  Sub-module lifo_ram #(WIDTH,DEPTH): one synchronous write port and one
//  asynchronous read port (raddr=top). It maps to MLAB/registers.
//  Top level: op decode, pointer/count registers, flags, strobe registers.
//
// TESTING
//  1. reset; push 0x101,0x202,0x303 -> count=3; pops return dout 0x303,0x202,0x101;
//     then empty=1, dout=0.
//  2. Empty: pop -> underflow=1 for exactly one cycle, count=0; then push+pop with
//     din=0x055 -> count=1, dout=0x055, underflow=1.
//  3. Push 1..16 (DEPTH=16) -> full=1; push+pop with din=0x7FF -> dout=0x7FF,
//     count=16, no strobe.
//  4. Full, push 0x0AA:
//     - without macro -> overflow=1, dout=16, count=16; 16 pops return 16..1.
//     - with macro -> dout=0x0AA; pops return 0x0AA,16..2, then empty.
//  5. Push 5 entries, assert reset together with push=1 -> count=0, empty=1;
//     next push 0x123 -> dout=0x123, count=1.
//  6. WIDTH=8, DEPTH=5: push 5, pop 5, push 5 again -> pointer wraps through
//     index 4->0 with data intact. Scoreboard against a queue model under
//     random push/pop.

Source files
------------

// File: rtl/lifo_stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
//   Shared types and helpers for the lifo_stack LIFO.
//   - stk_op_t : decoded per-cycle stack operation
//   - ptr_inc  : modular pointer increment with an explicit wrap compare
//   - ptr_dec  : modular pointer decrement with an explicit wrap compare
//   The pointer helpers do not rely on power-of-2 rollover, so any DEPTH >= 2
//   works.
// -----------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } stk_op_t;

    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic int unsigned ptr_dec(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr == 32'd0) ? depth - 32'd1 : ptr - 32'd1;
    endfunction

endpackage

// File: rtl/lifo_ram.sv
// -----------------------------------------------------------------------------
// lifo_ram
//   Storage array for lifo_stack: one synchronous write port and one
//   asynchronous read port. Contents are never reset.
//   Ports:
//     clk    in   clock, write on posedge
//     we     in   write enable
//     waddr  in   write address  [AW-1:0]
//     wdata  in   write data     [WIDTH-1:0]
//     raddr  in   read address   [AW-1:0]
//     rdata  out  read data      [WIDTH-1:0] (combinational)
// -----------------------------------------------------------------------------
module lifo_ram #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
//   Parametrised LIFO for return addresses and operand saves.
//   Full/empty flags, occupancy count, registered overflow/underflow strobes,
//   simultaneous push+pop replaces the top entry.
//   Build option:
//     LIFO_STACK_WRAP_EN  defined   -> push while full overwrites the oldest
//                         undefined -> push while full is dropped
//   Ports:
//     clk        in   clock, posedge
//     reset      in   synchronous, active-high, priority over push/pop
//     push       in   write din as new top
//     pop        in   discard current top
//     din        in   push data [WIDTH-1:0]
//     dout       out  current top, '0 when empty
//     empty      out  count == 0
//     full       out  count == DEPTH
//     count      out  valid entries [CW-1:0]
//     overflow   out  1-cycle strobe: push while full
//     underflow  out  1-cycle strobe: pop while empty
// -----------------------------------------------------------------------------
module lifo_stack
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [AW-1:0]    top_q, top_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    stk_op_t          op;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_inc, top_dec;
    logic [WIDTH-1:0] rdata;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign top_inc = AW'(ptr_inc(32'(top_q), DEPTH));
    assign top_dec = AW'(ptr_dec(32'(top_q), DEPTH));

    // push+pop on an empty stack has no top to replace, so it degrades to a push
    always_comb begin
        op = OP_NONE;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_REPL;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = top_inc;
        ovf_d   = 1'b0;
        unf_d   = pop && empty;
        unique case (op)
            OP_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    top_d   = top_inc;
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_d = 1'b1;
`ifdef LIFO_STACK_WRAP_EN
                    // slot after top holds the oldest entry when full
                    we    = 1'b1;
                    top_d = top_inc;
`endif
                end
            end
            OP_POP: begin
                if (!empty) begin
                    top_d   = top_dec;
                    count_d = count_q - CW'(1);
                end
            end
            OP_REPL: begin
                we    = 1'b1;
                waddr = top_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q   <= AW'(DEPTH - 1);
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // reset also blocks the write so a push issued with reset leaves no trace
    lifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we && !reset),
        .waddr (waddr),
        .wdata (din),
        .raddr (top_q),
        .rdata (rdata)
    );

    assign dout      = empty ? '0 : rdata;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack
//   Two instances: default 11x16 (dut_a) and 8x5 (dut_b, non power-of-2).
//   Each is compared against a queue model after every clock edge.
//   Define LIFO_STACK_WRAP_EN for both RTL and bench to check wrap mode.
// -----------------------------------------------------------------------------
module tb_lifo_stack;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, push_a, pop_a;
    logic [10:0] din_a, dout_a;
    logic        empty_a, full_a, ovf_a, unf_a;
    logic [4:0]  count_a;

    logic        reset_b, push_b, pop_b;
    logic [7:0]  din_b, dout_b;
    logic        empty_b, full_b, ovf_b, unf_b;
    logic [2:0]  count_b;

    lifo_stack #(.WIDTH(11), .DEPTH(16)) dut_a (
        .clk(clk), .reset(reset_a), .push(push_a), .pop(pop_a), .din(din_a),
        .dout(dout_a), .empty(empty_a), .full(full_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    lifo_stack #(.WIDTH(8), .DEPTH(5)) dut_b (
        .clk(clk), .reset(reset_b), .push(push_b), .pop(pop_b), .din(din_b),
        .dout(dout_b), .empty(empty_b), .full(full_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    int total = 0;
    int bad   = 0;
    int qa[$];
    int qb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stack semantics on a queue: back of queue is the top.
    task automatic model(input int id, input int dep, input bit rst, input bit ps,
                         input bit pp, input int d, output bit ov, output bit un);
        int q[$];
        if (id == 0) q = qa; else q = qb;
        ov = 1'b0;
        un = 1'b0;
        if (rst) begin
            q.delete();
        end else if (ps && pp) begin
            if (q.size() == 0) begin
                q.push_back(d);
                un = 1'b1;
            end else begin
                q[q.size() - 1] = d;
            end
        end else if (ps) begin
            if (q.size() < dep) begin
                q.push_back(d);
            end else begin
                ov = 1'b1;
`ifdef LIFO_STACK_WRAP_EN
                void'(q.pop_front());
                q.push_back(d);
`endif
            end
        end else if (pp) begin
            if (q.size() == 0) un = 1'b1;
            else void'(q.pop_back());
        end
        if (id == 0) qa = q; else qb = q;
    endtask

    task automatic step_a(input bit rst, input bit ps, input bit pp, input int d_in);
        bit ov, un;
        int d;
        int etop;
        d = d_in & 'h7FF;
        reset_a = rst; push_a = ps; pop_a = pp; din_a = d[10:0];
        @(posedge clk);
        #1;
        model(0, 16, rst, ps, pp, d, ov, un);
        etop = (qa.size() == 0) ? 0 : qa[qa.size() - 1];
        chk("a_count", 32'(count_a), qa.size());
        chk("a_empty", 32'(empty_a), 32'(qa.size() == 0));
        chk("a_full",  32'(full_a),  32'(qa.size() == 16));
        chk("a_dout",  32'(dout_a),  etop);
        chk("a_ovf",   32'(ovf_a),   32'(ov));
        chk("a_unf",   32'(unf_a),   32'(un));
    endtask

    task automatic step_b(input bit rst, input bit ps, input bit pp, input int d_in);
        bit ov, un;
        int d;
        int etop;
        d = d_in & 'hFF;
        reset_b = rst; push_b = ps; pop_b = pp; din_b = d[7:0];
        @(posedge clk);
        #1;
        model(1, 5, rst, ps, pp, d, ov, un);
        etop = (qb.size() == 0) ? 0 : qb[qb.size() - 1];
        chk("b_count", 32'(count_b), qb.size());
        chk("b_empty", 32'(empty_b), 32'(qb.size() == 0));
        chk("b_full",  32'(full_b),  32'(qb.size() == 5));
        chk("b_dout",  32'(dout_b),  etop);
        chk("b_ovf",   32'(ovf_b),   32'(ov));
        chk("b_unf",   32'(unf_b),   32'(un));
    endtask

    initial begin
        reset_a = 1'b1; push_a = 1'b0; pop_a = 1'b0; din_a = '0;
        reset_b = 1'b1; push_b = 1'b0; pop_b = 1'b0; din_b = '0;

        // reset state and LIFO order
        step_a(1, 0, 0, 0);
        step_a(0, 1, 0, 'h101);
        step_a(0, 1, 0, 'h202);
        step_a(0, 1, 0, 'h303);
        chk("t1_count3", 32'(count_a), 32'd3);
        step_a(0, 0, 1, 0);
        step_a(0, 0, 1, 0);
        step_a(0, 0, 1, 0);
        chk("t1_dout_empty", 32'(dout_a), 32'd0);

        // underflow strobe lasts one cycle; push+pop on empty acts as push
        step_a(0, 0, 1, 0);
        chk("t2_unf", 32'(unf_a), 32'd1);
        step_a(0, 0, 0, 0);
        chk("t2_unf_clear", 32'(unf_a), 32'd0);
        step_a(0, 1, 1, 'h055);
        chk("t2_pp_dout", 32'(dout_a), 32'h055);
        step_a(0, 0, 1, 0);

        // fill, replace top while full
        for (int i = 1; i <= 16; i++) step_a(0, 1, 0, i);
        chk("t3_full", 32'(full_a), 32'd1);
        step_a(0, 1, 1, 'h7FF);
        chk("t3_repl", 32'(dout_a), 32'h7FF);
        step_a(0, 1, 1, 16);

        // push while full, then drain completely
        step_a(0, 1, 0, 'h0AA);
        chk("t4_ovf", 32'(ovf_a), 32'd1);
        for (int i = 0; i < 17; i++) step_a(0, 0, 1, 0);

        // reset wins over a simultaneous push
        for (int i = 0; i < 5; i++) step_a(0, 1, 0, 'h40 + i);
        step_a(1, 1, 0, 'h3FF);
        chk("t5_rst_count", 32'(count_a), 32'd0);
        step_a(0, 1, 0, 'h123);
        chk("t5_dout", 32'(dout_a), 32'h123);

        // random phases alternating push-heavy and pop-heavy
        for (int i = 0; i < 600; i++) begin
            int r;
            int bias;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            r = int'($urandom_range(0, 99));
            step_a((i % 211) == 210, r < bias, int'($urandom_range(0, 99)) < 35 || r >= bias,
                   int'($urandom));
        end

        // small non power-of-2 instance: pointer wraps 4 -> 0
        step_b(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step_b(0, 1, 0, 'hA0 + i);
        for (int i = 0; i < 5; i++) step_b(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step_b(0, 1, 0, 'hC0 + i);
        step_b(0, 1, 0, 'h5A);
        for (int i = 0; i < 6; i++) step_b(0, 0, 1, 0);
        for (int i = 0; i < 500; i++) begin
            int r;
            r = int'($urandom_range(0, 3));
            step_b((i % 173) == 172, r[0], r[1], int'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
